// File: rtl/vec_beat_seq.sv
// Strip-mine beat sequencer: latches vl/vsew on issue and walks the active
// vector body in DATA_WIDTH-bit beats under a valid/ready handshake.
module vec_beat_seq #(
  parameter  int unsigned VLEN       = 16384,
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned VLMAX      = VLEN / 8,
  localparam int unsigned VL_BITS    = $clog2(VLMAX) + 1,
  localparam int unsigned BPB        = DATA_WIDTH / 8,
  localparam int unsigned BPB_LG     = $clog2(BPB),
  localparam int unsigned REM_W      = VL_BITS + 3,
  localparam int unsigned IDX_W      = VL_BITS + 3 - BPB_LG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               start_ready,
  input  logic [VL_BITS-1:0] vl,
  input  logic [2:0]         vsew,
  input  logic               vill,
  output logic               beat_valid,
  input  logic               beat_ready,
  output logic [IDX_W-1:0]   beat_idx,
  output logic [VL_BITS-1:0] beat_elem,
  output logic [BPB-1:0]     beat_be,
  output logic               beat_last,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REM_W-1:0]   r_rem;
  logic [IDX_W-1:0]   r_beat_idx;
  logic [1:0]         r_sew;

  logic               w_accept;
  logic               w_hs;
  logic               w_zero;
  logic               w_last;
  logic [REM_W-1:0]   w_rem_in;
  logic [REM_W-1:0]   w_byte_off;
  logic [VL_BITS-1:0] w_elem;
  logic [BPB-1:0]     w_be;

  // Issue decode: vsew[2] set means an encoding above e64.
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_hs       = (r_state == ST_RUN) && beat_ready;
  assign w_zero     = vill || vsew[2] || (vl == '0);
  assign w_rem_in   = REM_W'(vl) << vsew[1:0];

  // Beat decode from the latched remaining-byte count and beat counter.
  assign w_last     = (r_rem <= REM_W'(BPB));
  assign w_byte_off = {r_beat_idx, {BPB_LG{1'b0}}};
  assign w_elem     = VL_BITS'(w_byte_off >> r_sew);

  always_comb begin
    w_be = '0;
    for (int unsigned i = 0; i < BPB; i++) begin
      w_be[i] = (r_rem > REM_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat_ready && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Instruction context: remaining bytes, beat counter and element size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_beat_idx <= '0;
      r_sew      <= '0;
    end else if (w_accept) begin
      r_rem      <= w_rem_in;
      r_beat_idx <= '0;
      r_sew      <= vsew[1:0];
    end else if (w_hs && !w_last) begin
      r_rem      <= r_rem - REM_W'(BPB);
      r_beat_idx <= r_beat_idx + IDX_W'(1);
    end
  end

  // Outputs decoded from registered state; beat fields are zero unless valid.
  always_comb begin
    start_ready = 1'b0;
    beat_valid  = 1'b0;
    done        = 1'b0;
    beat_idx    = '0;
    beat_elem   = '0;
    beat_be     = '0;
    beat_last   = 1'b0;
    case (r_state)
      ST_IDLE: start_ready = 1'b1;
      ST_RUN: begin
        beat_valid = 1'b1;
        beat_idx   = r_beat_idx;
        beat_elem  = w_elem;
        beat_be    = w_be;
        beat_last  = w_last;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/vec_beat_seq.md
# vec_beat_seq

Strip-mine beat sequencer that sits directly downstream of the vector configuration stage. It latches the committed `vl` and `vsew` when an instruction is issued, then walks the active vector body in `DATA_WIDTH`-bit beats. For each beat it presents the beat index, the first element index and a byte-enable mask to the lane datapath under a valid/ready handshake. It signals completion with a one-cycle `done` pulse; instructions with `vl == 0` or illegal `vtype` complete without producing any beats.

## Interface
- `VLEN`, 16384: vector register length in bits.
- `VLMAX`, VLEN/8: maximum `vl`.
- `VL_BITS`, $clog2(VLMAX)+1: width of `vl`.
- `DATA_WIDTH`, 64: datapath beat width in bits, a power of 2 and at least 64; BPB = DATA_WIDTH/8 bytes per beat.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  issue request; accepted when `start && start_ready`.
- `start_ready`  out  1  high only in IDLE.
- `vl`  in  VL_BITS  active vector length; sampled on accept.
- `vsew`  in  3  SEW encoding (0=e8 … 3=e64); sampled on accept.
- `vill`  in  1  illegal vtype; sampled on accept.
- `beat_valid`  out  1  beat presented.
- `beat_ready`  in  1  datapath accepts the beat.
- `beat_idx`  out  VL_BITS+3-$clog2(BPB)  beat number, starting at 0.
- `beat_elem`  out  VL_BITS  index of the first element in the beat = (beat_idx*BPB) >> vsew.
- `beat_be`  out  BPB  byte enables for the beat.
- `beat_last`  out  1  final beat of the instruction.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `start_ready`=1.
  - RUN: `beat_valid`=1.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Accept in IDLE:
  - Latch `rem` = `vl << vsew`. Width is VL_BITS+3, with no truncation; maximum value is VLMAX*8.
  - Clear the beat counter.
  - If `vill`=1, `vsew`>3 or `vl`=0, go to DONE; otherwise go to RUN.
- In RUN:
  - `beat_be` = all ones if `rem` ≥ BPB, else (1<<`rem`)-1.
  - `beat_last` = (`rem` ≤ BPB).
- On a beat handshake (`beat_valid && beat_ready`):
  - If `beat_last`, go to DONE.
  - Otherwise `rem` -= BPB and the beat counter increments.
- Beat outputs stay stable while `beat_valid && !beat_ready`.
- `start` outside IDLE is ignored (`start_ready`=0); no queuing.
- `vl`/`vsew`/`vill` changing after accept have no effect on the instruction in flight.
- Beat count = ceil(`vl`·2^`vsew` / BPB); at most VLMAX*8/BPB.
- Beat outputs are 0 whenever `beat_valid`=0.

## Timing
- Reset (`rst_n` low, at any time, including mid-RUN):
  - State = IDLE, `start_ready`=1.
  - `beat_valid`, `beat_last`, `done`, `beat_idx`, `beat_elem`, `beat_be` = 0.
  - Reset takes effect immediately (asynchronously). Release is synchronous to `clk`.
  - An instruction in flight at reset is abandoned; no `done` is produced for it.
- Accept at edge T:
  - First `beat_valid` in cycle T+1 (latency 1).
  - For a zero-beat instruction, `done` is asserted in cycle T+1.
- With `beat_ready` held high: one beat per cycle, N beats in cycles T+1 … T+N.
- After the last handshake at edge E: `done` in cycle E+1; `start_ready` returns in E+2.
- Minimum issue-to-issue interval is N+2 cycles; a zero-beat instruction takes 2 cycles.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- **e8, short:** DATA_WIDTH=64, `vl`=5, `vsew`=0.
  - Expect 1 beat: `beat_be`=0x1F, `beat_last`=1, `beat_elem`=0.
  - `done` one cycle later.
- **e32, multiple beats:** `vl`=5, `vsew`=2 (20 bytes).
  - Expect 3 beats: `beat_be`=0xFF, 0xFF, 0x0F.
  - `beat_elem`=0, 2, 4; `beat_last` only on beat 2.
- **Zero-beat cases:** `vl`=0; separately `vill`=1 with `vl`=7.
  - Expect no `beat_valid`.
  - `done` in T+1, `start_ready` in T+2.
- **Backpressure:** `vl`=16, `vsew`=1 (4 beats), `beat_ready` toggling 1,0,0,1,…
  - Outputs hold stable while stalled.
  - Exactly 4 handshakes, `beat_idx` 0..3.
  - `start` pulsed mid-run is ignored.
- **Maximum length:** `vl`=VLMAX=2048, `vsew`=3.
  - Expect 2048 beats, all `beat_be`=0xFF.
  - `beat_idx` ends at 2047; no counter overflow.
- **Reset mid-run:** drive `rst_n` low during beat 1 of a 3-beat instruction.
  - Outputs go to reset values immediately; no `done`.
  - After release, a new instruction (`vl`=1, `vsew`=0) gives `beat_be`=0x01.
